rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the single register-file write port between NREQ writeback sources (e.g. ALU result,
//  load unit, CSR unit) using round-robin arbitration with a valid/ready handshake.
//  Tracks in-flight long-latency destinations in a 32-entry scoreboard.
//  Reports rs1/rs2 busy so decode can stall until the register file holds the value.
//  Sits between the execute/memory units and reg_file; drives reg_file rd_addr/rd_data/reg_write.
// PARAMETERS
//  NREQ  2   number of writeback sources (2..4); index 0 wins the first arbitration after reset
//  XLEN  32  data width
// PORTS
//  clk           in   1          clock, all state updates on posedge
//  rst           in   1          asynchronous, active-low reset
//  src_valid     in   NREQ       source i has a write pending
//  src_ready     out  NREQ       source i granted this cycle (one-hot or zero)
//  src_rd_addr   in   NREQ*5     destination per source, source i at [5i+4:5i]
//  src_rd_data   in   NREQ*XLEN  write data per source, source i at [XLEN*i+XLEN-1:XLEN*i]
//  mark_valid    in   1          decode issued a long-latency op; mark mark_addr busy
//  mark_addr     in   5          destination to mark
//  rs1_addr      in   5          decode read address 1
//  rs2_addr      in   5          decode read address 2
//  rs1_busy      out  1          rs1_addr has a pending write not yet in reg_file
//  rs2_busy      out  1          rs2_addr has a pending write not yet in reg_file
//  rf_rd_addr    out  5          to reg_file rd_addr
//  rf_rd_data    out  XLEN       to reg_file rd_data
//  rf_reg_write  out  1          to reg_file reg_write
// BEHAVIOUR
//  Reset (rst=0, async): rf_reg_write=0, rf_rd_addr=0, rf_rd_data=0, scoreboard all 0,
//   rr pointer selects source 0 first. src_ready and busy outputs are combinational:
//   0 and 0 while in reset.
//  Handshake: transfer on src_valid[i]&src_ready[i]. src_ready is combinational from src_valid.
//   A source holds valid, addr and data stable until ready. Sources never see backpressure
//   beyond arbitration loss.
//  Arbitration: at most one grant per cycle. Search starts at (last_granted+1) mod NREQ.
//   The pointer updates only on a grant. No valid inputs means no grant and the pointer is held.
//  Output stage: registered, 1-cycle latency. Grant in cycle N drives rf_* in cycle N+1.
//   reg_file writes at the end of N+1. With no grant, rf_reg_write=0 next cycle and
//   addr/data are held.
//  x0: grant with addr 0 is accepted (ready=1). It gives rf_reg_write=0 and touches no
//   scoreboard bit. mark_valid with mark_addr=0 is ignored.
//  Scoreboard: a bit is set at the edge with mark_valid. It is cleared at the edge where
//   rf_reg_write=1 for that addr. Same reg set and cleared on the same edge: set wins
//   (the newer instruction stays pending).
//  busy: rsX_busy = sb[rsX_addr] with rsX_addr != 0. No write-data bypass, so busy stays high
//   through cycle N+1 and drops in N+2.
//  Writes to unmarked registers (ALU results) are legal and leave the scoreboard unaffected.
//  Reset mid-operation: any in-flight output write is lost and all scoreboard bits are cleared.
// STRUCTURE
//  rv32i_pkg: XLEN, REG_ADDR_W=5, NUM_REGS=32, REG_X0 constant.
//  Sub-module rr_arbiter #(N): valid vector in, one-hot grant out, pointer register inside.
//  Top level holds the output register stage and the 32-bit scoreboard.
// TESTING
//  Reset: assert rst=0 mid-write -> rf_reg_write=0 immediately, all busy=0, next grant goes to src 0.
//  Single write: src0 valid rd=5 data=0xDEADBEEF in cycle 1 -> ready0=1 in cycle 1;
//   rf_reg_write=1, addr 5, data 0xDEADBEEF in cycle 2.
//  Contention: src0 and src1 held valid for 4 cycles -> grants 0,1,0,1 and 4 writes in order.
//  Scoreboard: mark x7 in cycle 1; rs1_addr=7 -> busy from cycle 2; src1 writes x7 granted in
//   cycle 5 -> busy high in cycle 6, low in cycle 7.
//  Set/clear collision: rf_reg_write to x9 and mark x9 on the same edge -> x9 busy remains 1.
//  x0: mark x0 and write x0 -> ready=1, rf_reg_write stays 0, rs1_busy(x0)=0 throughout.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared register-file constants and types for the writeback path.
package rv32i_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t REG_X0 = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the last winner.
module rr_arbiter #(
   parameter int N = 2,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] gnt_idx;
   logic [PW-1:0] idx;
   logic          found;

   always_comb begin
      gnt     = '0;
      gnt_idx = ptr_q;
      idx     = ptr_q;
      found   = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(ptr_q) + k) % N);
         if (!found && req[idx]) begin
            found      = 1'b1;
            gnt[idx]   = 1'b1;
            gnt_idx    = idx;
         end
      end
      // Pointer moves only on a grant; idle cycles keep the fairness order.
      ptr_d = ptr_q;
      if (found) begin
         ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin port sharing, registered write stage
// and a pending-destination scoreboard that drives decode busy flags.
module rf_wb_arbiter #(
   parameter int NREQ = 2,
   parameter int XLEN = rv32i_pkg::XLEN
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NREQ-1:0]                         src_valid,
   output logic [NREQ-1:0]                         src_ready,
   input  logic [NREQ*rv32i_pkg::REG_ADDR_W-1:0]   src_rd_addr,
   input  logic [NREQ*XLEN-1:0]                    src_rd_data,
   input  logic                                    mark_valid,
   input  logic [rv32i_pkg::REG_ADDR_W-1:0]        mark_addr,
   input  logic [rv32i_pkg::REG_ADDR_W-1:0]        rs1_addr,
   input  logic [rv32i_pkg::REG_ADDR_W-1:0]        rs2_addr,
   output logic                                    rs1_busy,
   output logic                                    rs2_busy,
   output logic [rv32i_pkg::REG_ADDR_W-1:0]        rf_rd_addr,
   output logic [XLEN-1:0]                         rf_rd_data,
   output logic                                    rf_reg_write
);

   import rv32i_pkg::*;

   logic [NREQ-1:0]     gnt;
   logic                any_gnt;
   reg_addr_t           sel_addr;
   logic [XLEN-1:0]     sel_data;

   logic                rf_we_q,   rf_we_d;
   reg_addr_t           rf_addr_q, rf_addr_d;
   logic [XLEN-1:0]     rf_data_q, rf_data_d;
   logic [NUM_REGS-1:0] sb_q,      sb_d;

   rr_arbiter #(.N(NREQ)) u_arb (
      .clk (clk),
      .rst (rst),
      .req (src_valid),
      .gnt (gnt)
   );

   // Handshake: source i transfers in any cycle where src_valid[i] && src_ready[i].
   // Ready is a pure function of the valid vector (never of the data), at most one
   // bit is set, and a source must hold valid/addr/data stable until it sees ready.
   assign src_ready = rst ? gnt : '0;

   always_comb begin
      any_gnt  = |src_ready;
      sel_addr = REG_X0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (src_ready[i]) begin
            sel_addr = src_rd_addr[i*REG_ADDR_W +: REG_ADDR_W];
            sel_data = src_rd_data[i*XLEN +: XLEN];
         end
      end

      // x0 grants complete the handshake but never reach the register file.
      rf_we_d   = any_gnt && (sel_addr != REG_X0);
      rf_addr_d = any_gnt ? sel_addr : rf_addr_q;
      rf_data_d = any_gnt ? sel_data : rf_data_q;

      // Clear first, then set, so a new mark on the retiring register stays pending.
      sb_d = sb_q;
      if (rf_we_q) begin
         sb_d[rf_addr_q] = 1'b0;
      end
      if (mark_valid && (mark_addr != REG_X0)) begin
         sb_d[mark_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_we_q   <= 1'b0;
         rf_addr_q <= REG_X0;
         rf_data_q <= '0;
         sb_q      <= '0;
      end else begin
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
         sb_q      <= sb_d;
      end
   end

   assign rs1_busy     = (rs1_addr != REG_X0) && sb_q[rs1_addr];
   assign rs2_busy     = (rs2_addr != REG_X0) && sb_q[rs2_addr];
   assign rf_reg_write = rf_we_q;
   assign rf_rd_addr   = rf_addr_q;
   assign rf_rd_data   = rf_data_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: per-feature tasks plus a writeback scoreboard queue.
module tb_rf_wb_arbiter;

   localparam int NREQ = 2;
   localparam int XLEN = 32;
   localparam int W    = 5 + XLEN;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      src_valid;
   logic [NREQ-1:0]      src_ready;
   logic [NREQ*5-1:0]    src_rd_addr;
   logic [NREQ*XLEN-1:0] src_rd_data;
   logic                 mark_valid;
   logic [4:0]           mark_addr;
   logic [4:0]           rs1_addr;
   logic [4:0]           rs2_addr;
   logic                 rs1_busy;
   logic                 rs2_busy;
   logic [4:0]           rf_rd_addr;
   logic [XLEN-1:0]      rf_rd_data;
   logic                 rf_reg_write;

   int             n_vec = 0;
   int             n_err = 0;
   int             m_ptr = 0;
   logic [W-1:0]   exp_q[$];

   rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
      .clk          (clk),
      .rst          (rst),
      .src_valid    (src_valid),
      .src_ready    (src_ready),
      .src_rd_addr  (src_rd_addr),
      .src_rd_data  (src_rd_data),
      .mark_valid   (mark_valid),
      .mark_addr    (mark_addr),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .rs1_busy     (rs1_busy),
      .rs2_busy     (rs2_busy),
      .rf_rd_addr   (rf_rd_addr),
      .rf_rd_data   (rf_rd_data),
      .rf_reg_write (rf_reg_write)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- drivers and reference model ----------------
   task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic mv, input logic [4:0] ma);
      @(posedge clk);
      #1;
      src_valid   = v;
      src_rd_addr = {a1, a0};
      src_rd_data = {d1, d0};
      mark_valid  = mv;
      mark_addr   = ma;
      #1;
   endtask

   task automatic idle();
      drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      rst        = 1'b0;
      src_valid  = '0;
      mark_valid = 1'b0;
      @(posedge clk);
      #1;
      rst   = 1'b1;
      m_ptr = 0;
   endtask

   // Expected grant: first requester at or after the model pointer, wrapping.
   task automatic model_grant(input logic [1:0] v, output logic [1:0] g);
      int start;
      g     = '0;
      start = m_ptr;
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (start + k) % NREQ;
         if (g == 2'b00 && v[i]) begin
            g[i]  = 1'b1;
            m_ptr = (i + 1) % NREQ;
         end
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic monitor();
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            exp_q.delete();
         end else begin
            if (rf_reg_write === 1'b1) begin
               n_vec++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL wb_write: unexpected write addr=%0d data=%h, required none",
                           rf_rd_addr, rf_rd_data);
               end else begin
                  e = exp_q.pop_front();
                  if ({rf_rd_addr, rf_rd_data} !== e) begin
                     n_err++;
                     $display("FAIL wb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                              rf_rd_addr, rf_rd_data, e[W-1:XLEN], e[XLEN-1:0]);
                  end
               end
            end else if (exp_q.size() != 0) begin
               e = exp_q[0];
               n_vec++;
               n_err++;
               $display("FAIL wb_write: got no write (we=%b), required addr=%0d data=%h",
                        rf_reg_write, e[W-1:XLEN], e[XLEN-1:0]);
               exp_q.delete();
            end
            for (int i = 0; i < NREQ; i++) begin
               if (src_valid[i] && src_ready[i] && src_rd_addr[5*i +: 5] != 5'd0) begin
                  exp_q.push_back({src_rd_addr[5*i +: 5], src_rd_data[XLEN*i +: XLEN]});
               end
            end
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [1:0] g;
      rst = 1'b0;
      src_valid = 2'b11; src_rd_addr = {5'd2, 5'd1}; src_rd_data = 64'h1;
      mark_valid = 1'b1; mark_addr = 5'd4; rs1_addr = 5'd4; rs2_addr = 5'd4;
      repeat (2) @(posedge clk);
      #2;
      n_vec++; if (rf_reg_write !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b required 0", rf_reg_write); end
      n_vec++; if (rf_rd_addr !== 5'd0) begin n_err++; $display("FAIL reset_addr: got %0d required 0", rf_rd_addr); end
      n_vec++; if (rf_rd_data !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h required 0", rf_rd_data); end
      n_vec++; if (src_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b required 00", src_ready); end
      n_vec++; if ({rs1_busy, rs2_busy} !== 2'b00) begin n_err++; $display("FAIL reset_busy: got %b required 00", {rs1_busy, rs2_busy}); end
      @(posedge clk);
      #1;
      rst = 1'b1; src_valid = '0; mark_valid = 1'b0; m_ptr = 0;
      drive(2'b11, 5'd1, 5'd2, 32'h1111_0001, 32'h2222_0002, 1'b0, 5'd0);
      n_vec++; if (src_ready !== 2'b01) begin n_err++; $display("FAIL reset_first_grant: got %b required 01", src_ready); end
      model_grant(2'b11, g);
      drive(2'b10, 5'd1, 5'd2, 32'h1111_0001, 32'h2222_0002, 1'b0, 5'd0);
      model_grant(2'b10, g);
      n_vec++; if (src_ready !== g) begin n_err++; $display("FAIL reset_second_grant: got %b required %b", src_ready, g); end
      idle();
      n_vec++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL reset_mark_ignored: got %b required 0", rs1_busy); end
   endtask

   task automatic test_single();
      logic [1:0] g;
      drive(2'b01, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'd0, 1'b0, 5'd0);
      model_grant(2'b01, g);
      n_vec++; if (src_ready !== 2'b01) begin n_err++; $display("FAIL single_ready: got %b required 01", src_ready); end
      idle();
      n_vec++; if (rf_reg_write !== 1'b1) begin n_err++; $display("FAIL single_we: got %b required 1", rf_reg_write); end
      n_vec++; if (rf_rd_addr !== 5'd5) begin n_err++; $display("FAIL single_addr: got %0d required 5", rf_rd_addr); end
      n_vec++; if (rf_rd_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_data: got %h required deadbeef", rf_rd_data); end
      idle();
      n_vec++; if (rf_reg_write !== 1'b0) begin n_err++; $display("FAIL single_we_off: got %b required 0", rf_reg_write); end
      n_vec++; if (rf_rd_addr !== 5'd5) begin n_err++; $display("FAIL single_addr_hold: got %0d required 5", rf_rd_addr); end
   endtask

   task automatic test_contention();
      logic [1:0]  g;
      logic [4:0]  a[2];
      logic [31:0] d[2];
      apply_reset();
      a[0] = 5'd10; a[1] = 5'd11; d[0] = $urandom; d[1] = $urandom;
      for (int c = 0; c < 4; c++) begin
         drive(2'b11, a[0], a[1], d[0], d[1], 1'b0, 5'd0);
         model_grant(2'b11, g);
         n_vec++;
         if (src_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
            n_err++;
            $display("FAIL contention_grant%0d: got %b required %b", c, src_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
         end
         for (int i = 0; i < 2; i++) begin
            if (g[i]) begin
               a[i] = a[i] + 5'd2;
               d[i] = $urandom;
            end
         end
      end
      idle();
      idle();
   endtask

   task automatic test_scoreboard();
      logic [1:0] g;
      rs1_addr = 5'd7; rs2_addr = 5'd8;
      drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd7);
      n_vec++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL sb_before_mark: got %b required 0", rs1_busy); end
      for (int c = 2; c <= 4; c++) begin
         idle();
         n_vec++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL sb_busy_c%0d: got %b required 1", c, rs1_busy); end
      end
      n_vec++; if (rs2_busy !== 1'b0) begin n_err++; $display("FAIL sb_rs2_free: got %b required 0", rs2_busy); end
      drive(2'b10, 5'd0, 5'd7, 32'd0, $urandom, 1'b0, 5'd0);
      model_grant(2'b10, g);
      n_vec++; if (src_ready !== 2'b10) begin n_err++; $display("FAIL sb_write_ready: got %b required 10", src_ready); end
      n_vec++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL sb_busy_c5: got %b required 1", rs1_busy); end
      idle();
      n_vec++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL sb_busy_c6: got %b required 1", rs1_busy); end
      idle();
      n_vec++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL sb_busy_c7: got %b required 0", rs1_busy); end
   endtask

   task automatic test_collision();
      logic [1:0] g;
      rs1_addr = 5'd9; rs2_addr = 5'd9;
      drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd9);
      drive(2'b01, 5'd9, 5'd0, 32'h0000_0909, 32'd0, 1'b0, 5'd0);
      model_grant(2'b01, g);
      n_vec++; if (src_ready !== g) begin n_err++; $display("FAIL coll_ready: got %b required %b", src_ready, g); end
      drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd9);
      n_vec++; if ({rf_reg_write, rf_rd_addr} !== {1'b1, 5'd9}) begin n_err++; $display("FAIL coll_write: got we=%b addr=%0d required we=1 addr=9", rf_reg_write, rf_rd_addr); end
      idle();
      n_vec++; if (rs2_busy !== 1'b1) begin n_err++; $display("FAIL coll_set_wins: got %b required 1", rs2_busy); end
      drive(2'b01, 5'd9, 5'd0, 32'h0000_0A0A, 32'd0, 1'b0, 5'd0);
      model_grant(2'b01, g);
      idle();
      n_vec++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL coll_busy_n1: got %b required 1", rs1_busy); end
      idle();
      n_vec++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL coll_cleared: got %b required 0", rs1_busy); end
   endtask

   task automatic test_x0();
      logic [1:0] g;
      rs1_addr = 5'd0; rs2_addr = 5'd0;
      drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0);
      n_vec++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL x0_busy_mark: got %b required 0", rs1_busy); end
      drive(2'b01, 5'd0, 5'd0, $urandom, 32'd0, 1'b0, 5'd0);
      model_grant(2'b01, g);
      n_vec++; if (src_ready !== 2'b01) begin n_err++; $display("FAIL x0_ready: got %b required 01", src_ready); end
      n_vec++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL x0_busy: got %b required 0", rs1_busy); end
      idle();
      n_vec++; if (rf_reg_write !== 1'b0) begin n_err++; $display("FAIL x0_no_write: got %b required 0", rf_reg_write); end
      n_vec++; if (rs2_busy !== 1'b0) begin n_err++; $display("FAIL x0_busy_after: got %b required 0", rs2_busy); end
   endtask

   task automatic test_reset_mid();
      logic [1:0] g;
      rs1_addr = 5'd3; rs2_addr = 5'd12;
      drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd3);
      drive(2'b01, 5'd12, 5'd13, 32'hC0C0_0012, 32'hC0C0_0013, 1'b0, 5'd0);
      model_grant(2'b01, g);
      @(posedge clk);
      #1;
      src_valid = 2'b11;
      n_vec++; if (rf_reg_write !== 1'b1) begin n_err++; $display("FAIL rmid_pre_write: got %b required 1", rf_reg_write); end
      n_vec++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL rmid_pre_busy: got %b required 1", rs1_busy); end
      rst = 1'b0;
      #1;
      n_vec++; if (rf_reg_write !== 1'b0) begin n_err++; $display("FAIL rmid_we: got %b required 0", rf_reg_write); end
      n_vec++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b required 0", rs1_busy); end
      n_vec++; if (src_ready !== 2'b00) begin n_err++; $display("FAIL rmid_ready: got %b required 00", src_ready); end
      @(posedge clk);
      #1;
      rst = 1'b1; m_ptr = 0;
      #1;
      model_grant(2'b11, g);
      n_vec++; if (src_ready !== 2'b01) begin n_err++; $display("FAIL rmid_next_grant: got %b required 01", src_ready); end
      drive(2'b10, 5'd12, 5'd13, 32'hC0C0_0012, 32'hC0C0_0013, 1'b0, 5'd0);
      model_grant(2'b10, g);
      idle();
      idle();
   endtask

   task automatic test_random();
      logic [1:0]  g;
      logic [1:0]  v;
      logic        pend[2];
      logic [4:0]  a[2];
      logic [31:0] d[2];
      pend[0] = 1'b0; pend[1] = 1'b0;
      a[0] = 5'd0; a[1] = 5'd0; d[0] = 32'd0; d[1] = 32'd0;
      for (int c = 0; c < 40; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1'b1;
               a[i]    = 5'($urandom_range(0, 31));
               d[i]    = $urandom;
            end
         end
         v = {pend[1], pend[0]};
         rs1_addr = 5'($urandom_range(0, 31));
         drive(v, a[0], a[1], d[0], d[1], 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
         model_grant(v, g);
         n_vec++;
         if (src_ready !== g) begin
            n_err++;
            $display("FAIL random_grant_c%0d: got %b required %b (valid %b)", c, src_ready, g, v);
         end
         for (int i = 0; i < 2; i++) begin
            if (g[i]) pend[i] = 1'b0;
         end
      end
      idle();
      idle();
   endtask

   initial begin
      rst = 1'b0;
      src_valid = '0; src_rd_addr = '0; src_rd_data = '0;
      mark_valid = 1'b0; mark_addr = '0; rs1_addr = '0; rs2_addr = '0;
      fork
         monitor();
      join_none
      test_reset();
      test_single();
      test_contention();
      test_scoreboard();
      test_collision();
      test_x0();
      test_reset_mid();
      test_random();
      repeat (3) @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
